// File: rtl/rs_encoder_top.sv
// rs_encoder_top: systematic RS(255,239) encoder over GF(2^8), t = 8.
// Free-running symbol stream with one symbol per clock. An internal counter
// frames the stream into blocks: 239 message symbols pass straight through,
// then 16 parity symbols are emitted, highest degree first. Blocks are
// back-to-back, and the parity register drains to zero between blocks.
module rs_encoder_top (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] m,
   output logic [7:0] c
);

   localparam int unsigned SW        = 8;
   localparam int unsigned N         = 255;
   localparam int unsigned K         = 239;
   localparam int unsigned NP        = N - K;
   localparam int unsigned CW        = 8;
   localparam int unsigned FCR       = 0;
   localparam logic [8:0]  PRIM_POLY = 9'h11D;
   localparam logic [7:0]  ALPHA     = 8'h02;

   // Multiply by alpha (x), reducing modulo the field polynomial.
   function automatic logic [SW-1:0] gf_xtime(input logic [SW-1:0] a);
      return {a[SW-2:0], 1'b0} ^ (a[SW-1] ? PRIM_POLY[SW-1:0] : SW'(0));
   endfunction

   // General GF(2^8) multiply. Every call with a constant operand folds down
   // to a small XOR network.
   function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b);
      logic [SW-1:0] acc;
      logic [SW-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < int'(SW); i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf_xtime(sh);
      end
      return acc;
   endfunction

   // Generator polynomial g(x) = prod (x + alpha^i), i = FCR..FCR+NP-1.
   // The result packs g0..g(NP-1); the monic g(NP) = 1 is implicit.
   function automatic logic [NP*SW-1:0] gen_poly();
      logic [SW-1:0]    g [NP+1];
      logic [SW-1:0]    root;
      logic [NP*SW-1:0] packed_g;
      for (int j = 0; j <= int'(NP); j++) g[j] = '0;
      g[0] = SW'(1);
      root = SW'(1);
      for (int i = 0; i < int'(FCR); i++) root = gf_mul(root, ALPHA);
      for (int i = 0; i < int'(NP); i++) begin
         for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
         g[0] = gf_mul(g[0], root);
         root = gf_mul(root, ALPHA);
      end
      packed_g = '0;
      for (int j = 0; j < int'(NP); j++) packed_g[j*SW +: SW] = g[j];
      return packed_g;
   endfunction

   localparam logic [NP*SW-1:0] G_COEF = gen_poly();

   logic [CW-1:0] r_cnt;
   logic [SW-1:0] r_par [NP];
   logic [SW-1:0] r_c;

   logic          w_msg_phase;
   logic [SW-1:0] w_fb;
   logic [SW-1:0] w_c_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [SW-1:0] w_par_nxt [NP];

   // Next-state logic: LFSR division during the message phase, plain shift-out during the parity phase.
   always_comb begin
      w_msg_phase = (r_cnt < CW'(K));
      w_fb        = m ^ r_par[NP-1];
      w_c_nxt     = r_par[NP-1];
      w_cnt_nxt   = (r_cnt == CW'(N - 1)) ? CW'(0) : r_cnt + CW'(1);
      w_par_nxt[0] = '0;
      for (int j = 1; j < int'(NP); j++) w_par_nxt[j] = r_par[j-1];
      if (w_msg_phase) begin
         w_c_nxt      = m;
         w_par_nxt[0] = gf_mul(w_fb, G_COEF[0 +: SW]);
         for (int j = 1; j < int'(NP); j++)
            w_par_nxt[j] = r_par[j-1] ^ gf_mul(w_fb, G_COEF[j*SW +: SW]);
      end
   end

   // State registers: synchronous active-low reset aborts any block in progress.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
         r_c   <= '0;
         for (int j = 0; j < int'(NP); j++) r_par[j] <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_c   <= w_c_nxt;
         for (int j = 0; j < int'(NP); j++) r_par[j] <= w_par_nxt[j];
      end
   end

   assign c = r_c;

endmodule

// File: tb/tb_rs_encoder_top.sv
// tb_rs_encoder_top: directed checks of the RS(255,239) encoder.
// Reference parity comes from polynomial long division by g(x), and every
// codeword also has its 16 syndromes checked independently of g(x).
module tb_rs_encoder_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] m;
   logic [7:0] c;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] g_ref [17];
   logic [7:0] msg_a [255];
   logic [7:0] out_a [255];

   rs_encoder_top dut (
      .clk (clk),
      .rst (rst),
      .m   (m),
      .c   (c)
   );

   always #5 clk = ~clk;

   // GF(2^8) multiply modulo 0x11D, MSB-first Horner form.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Hold reset for n edges with arbitrary m; c must read 0 after each edge.
   task automatic apply_reset(input int n);
      for (int e = 0; e < n; e++) begin
         rst = 1'b0;
         m   = 8'($urandom);
         @(posedge clk);
         #1;
         chk("reset c", c, 8'h00);
      end
   endtask

   // Drive the first n symbols of msg_a and capture c after each edge.
   task automatic run_steps(input int n);
      for (int k = 0; k < n; k++) begin
         rst = 1'b1;
         m   = msg_a[k];
         @(posedge clk);
         #1;
         out_a[k] = c;
      end
   endtask

   // Check pass-through, parity against long division, optional g(x) match, and syndromes.
   task automatic check_block(input string name, input bit check_g);
      logic [7:0] d [255];
      logic [7:0] coef;
      logic [7:0] a;
      logic [7:0] s;
      for (int k = 0; k < 255; k++) d[k] = (k < 239) ? msg_a[k] : 8'h00;
      for (int k = 0; k < 239; k++) begin
         coef = d[k];
         for (int j = 0; j <= 16; j++) d[k+j] = d[k+j] ^ gmul(coef, g_ref[16-j]);
      end
      for (int k = 0; k < 239; k++)
         chk($sformatf("%s msg[%0d]", name, k), out_a[k], msg_a[k]);
      for (int j = 0; j < 16; j++)
         chk($sformatf("%s par[%0d]", name, j), out_a[239+j], d[239+j]);
      if (check_g)
         for (int j = 0; j < 16; j++)
            chk($sformatf("%s g[%0d]", name, 15 - j), out_a[239+j], g_ref[15-j]);
      a = 8'h01;
      for (int i = 0; i < 16; i++) begin
         s = 8'h00;
         for (int k = 0; k < 255; k++) s = gmul(s, a) ^ out_a[k];
         chk($sformatf("%s syn[%0d]", name, i), s, 8'h00);
         a = gmul(a, 8'h02);
      end
   endtask

   initial begin
      logic [7:0] root;

      // Reference generator polynomial, ascending coefficients, g16 = 1.
      for (int j = 0; j < 17; j++) g_ref[j] = 8'h00;
      g_ref[0] = 8'h01;
      root     = 8'h01;
      for (int i = 0; i < 16; i++) begin
         for (int j = i + 1; j >= 1; j--) g_ref[j] = g_ref[j-1] ^ gmul(g_ref[j], root);
         g_ref[0] = gmul(g_ref[0], root);
         root     = gmul(root, 8'h02);
      end

      rst = 1'b0;
      m   = 8'h00;
      apply_reset(3);

      // Ramp for three back-to-back blocks: starts 0, 255, 254 (mod 256).
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < 255; k++) msg_a[k] = 8'(b * 255 + k);
         run_steps(255);
         check_block($sformatf("ramp%0d", b), 1'b0);
      end

      // All-zero message yields an all-zero codeword.
      apply_reset(1);
      for (int k = 0; k < 255; k++) msg_a[k] = 8'h00;
      run_steps(255);
      check_block("zero", 1'b0);

      // A single 1 in the last message slot, x^16 mod g(x), gives parity g15..g0.
      for (int k = 0; k < 255; k++) msg_a[k] = 8'h00;
      msg_a[238] = 8'h01;
      run_steps(255);
      check_block("unit", 1'b1);

      // Abort a block at cnt = 100, then encode a fresh block.
      for (int k = 0; k < 255; k++) msg_a[k] = 8'(k + 7);
      run_steps(100);
      chk("partial first", out_a[0], 8'h07);
      chk("partial last", out_a[99], 8'(106));
      apply_reset(2);
      for (int k = 0; k < 255; k++) msg_a[k] = 8'(k * 37 + 5);
      run_steps(255);
      check_block("post_abort", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
